// File: rtl/auto_mov_seq_if.sv
// ============================================================================
// Module      : auto_mov_seq_if
// Description : Command/status bundle between a pose source and auto_mov_seq.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface auto_mov_seq_if #(
    parameter int N_CH  = 5,
    parameter int POS_W = 8
);
    logic                    sw;
    logic                    serial;
    logic [N_CH*POS_W-1:0]   pos;
    logic [2*N_CH-1:0]       btn;
    logic [N_CH*POS_W-1:0]   cur;
    logic                    busy;
    logic                    done;

    modport master (output sw, serial, pos, input  btn, cur, busy, done);
    modport slave  (input  sw, serial, pos, output btn, cur, busy, done);
endinterface

`default_nettype wire

// File: rtl/auto_mov_seq.sv
// ============================================================================
// Module      : auto_mov_seq
// Description : Paced per-joint move sequencer emitting up/down button pulses.
//               Optional target clamping enabled by the MOV_LIMIT_EN macro.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module auto_mov_seq #(
    parameter int               N_CH     = 5,
    parameter int               POS_W    = 8,
    parameter int               STEP_DIV = 4,
    parameter logic [POS_W-1:0] HOME     = 8'h40,
    parameter logic [POS_W-1:0] MIN_POS  = '0,
    parameter logic [POS_W-1:0] MAX_POS  = '1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    auto_mov_seq_if.slave      bus
);

    localparam int c_CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int c_IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_RELOAD = c_CNT_W'(STEP_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_ch_idx;
    logic                 r_serial;
    logic [POS_W-1:0]     r_tgt [N_CH];
    logic [POS_W-1:0]     r_cur [N_CH];
    logic [2*N_CH-1:0]    r_btn;
    logic [POS_W-1:0]     w_tgt_in [N_CH];
    logic [N_CH-1:0]      w_move;
    logic                 w_any_move;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [POS_W-1:0] w_pos;
            assign w_pos = bus.pos[i*POS_W +: POS_W];
`ifdef MOV_LIMIT_EN
            assign w_tgt_in[i] = (int'(w_pos) < int'(MIN_POS)) ? MIN_POS :
                                 (int'(w_pos) > int'(MAX_POS)) ? MAX_POS : w_pos;
`else
            assign w_tgt_in[i] = w_pos;
`endif
            // A channel participates when it is off target and in the active set
            assign w_move[i] = (r_cur[i] != r_tgt[i]) &&
                               (!r_serial || (r_ch_idx == c_IDX_W'(i)));
            assign bus.cur[i*POS_W +: POS_W] = r_cur[i];
        end : g_ch
    endgenerate

`ifndef MOV_LIMIT_EN
    logic w_unused_lim;
    assign w_unused_lim = ^{MIN_POS, MAX_POS};
`endif

    assign w_any_move = |w_move;
    assign bus.btn    = r_btn;
    assign bus.busy   = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_STEP);
    assign bus.done   = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.sw) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = bus.sw ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!bus.sw)            w_state_nxt = S_IDLE;
                else if (r_cnt == '0)   w_state_nxt = S_STEP;
            end
            S_STEP: begin
                if (!bus.sw)                                 w_state_nxt = S_IDLE;
                else if (w_any_move)                         w_state_nxt = S_WAIT;
                else if (r_serial && (r_ch_idx != c_IDX_LAST)) w_state_nxt = S_STEP;
                else                                         w_state_nxt = S_DONE;
            end
            S_DONE: if (!bus.sw) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pulses last one cycle; an abort edge never issues a pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_ch_idx <= '0;
            r_serial <= 1'b0;
            r_btn    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cur[i] <= HOME;
                r_tgt[i] <= HOME;
            end
        end else begin
            r_btn <= '0;
            case (r_state)
                S_LOAD: begin
                    if (bus.sw) begin
                        r_tgt    <= w_tgt_in;
                        r_serial <= bus.serial;
                        r_ch_idx <= '0;
                        r_cnt    <= c_CNT_RELOAD;
                    end
                end
                S_WAIT: begin
                    if (bus.sw && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
                end
                S_STEP: begin
                    if (bus.sw) begin
                        if (w_any_move) begin
                            for (int i = 0; i < N_CH; i++) begin
                                if (w_move[i]) begin
                                    if (r_cur[i] < r_tgt[i]) begin
                                        r_cur[i]     <= r_cur[i] + 1'b1;
                                        r_btn[2*i]   <= 1'b1;
                                    end else begin
                                        r_cur[i]     <= r_cur[i] - 1'b1;
                                        r_btn[2*i+1] <= 1'b1;
                                    end
                                end
                            end
                            r_cnt <= c_CNT_RELOAD;
                        end else if (r_serial && (r_ch_idx != c_IDX_LAST)) begin
                            r_ch_idx <= r_ch_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
